fetch_unit: RTL and testbench

Instruction-fetch stage that owns the architectural PC and feeds the decode/control stage. It issues one instruction-memory request at a time and presents the fetched word to decode with a valid/ready handshake. It selects the next PC from the control stage's pc_source (PC_PLUS_4, PC_BRANCH, PC_JUMP, PC_MTVEC, PC_MEPC). It drops in-flight fetches on redirects and flags misaligned fetch targets.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the architectural PC, keeps at most
// one instruction-memory request in flight and hands each fetched word to
// decode through a valid/ready pair. Redirects flush the stage; a response that
// was already in flight at the time of a redirect is swallowed. Misaligned
// fetch targets park the stage in TRAP until the next redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      pc_source,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_misalign
);

  // Encodings of the control stage's pc_source selector.
  localparam logic [2:0] PC_PLUS_4 = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_MTVEC  = 3'd3;
  localparam logic [2:0] PC_MEPC   = 3'd4;

  localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] JUMP_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // request outstanding on the memory port
    WAIT = 2'd1,  // request accepted, waiting for read data
    HOLD = 2'd2,  // instruction presented to decode
    TRAP = 2'd3   // misaligned PC, no fetch until redirected
  } fetchState_t;

  fetchState_t     state_r;
  logic [XLEN-1:0] pc_r;
  logic            imemReq_r;
  logic            instrValid_r;
  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] instrPc_r;
  logic            misalign_r;
  logic            drop_r;

  logic [XLEN-1:0] nextPc_s;
  logic            nextMis_s;
  logic            pcMis_s;
  logic            accepted_s;

  // Next-PC selection; unused encodings fall back to sequential fetch.
  always_comb begin
    nextPc_s = pc_r + PC_STEP;
    case (pc_source)
      PC_PLUS_4: nextPc_s = pc_r + PC_STEP;
      PC_BRANCH: nextPc_s = branch_target;
      PC_JUMP:   nextPc_s = jump_target & JUMP_MASK;
      PC_MTVEC:  nextPc_s = mtvec & MTVEC_MASK;
      PC_MEPC:   nextPc_s = mepc;
      default:   nextPc_s = pc_r + PC_STEP;
    endcase
  end

  assign nextMis_s  = (nextPc_s[1:0] != 2'b00);
  assign pcMis_s    = (pc_r[1:0] != 2'b00);
  // The request line is low for one cycle after reset, so a grant only counts
  // while the request is actually being driven.
  assign accepted_s = imemReq_r & imem_gnt;

  // Fetch sequencer: advances the FSM and owns every registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      imemReq_r    <= 1'b0;
      instrValid_r <= 1'b0;
      instr_r      <= NOP_INSTR;
      instrPc_r    <= RESET_PC;
      misalign_r   <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          if (redirect) begin
            pc_r         <= nextPc_s;
            instrValid_r <= 1'b0;
            if (accepted_s) begin
              // The old address was accepted in this very cycle: its data
              // must still be collected, then thrown away.
              drop_r    <= 1'b1;
              state_r   <= WAIT;
              imemReq_r <= 1'b0;
            end else begin
              state_r    <= nextMis_s ? TRAP : REQ;
              imemReq_r  <= ~nextMis_s;
              misalign_r <= nextMis_s;
            end
          end else if (accepted_s) begin
            state_r   <= WAIT;
            imemReq_r <= 1'b0;
          end else begin
            imemReq_r <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              pc_r         <= nextPc_s;
              drop_r       <= 1'b0;
              instrValid_r <= 1'b0;
              state_r      <= nextMis_s ? TRAP : REQ;
              imemReq_r    <= ~nextMis_s;
              misalign_r   <= nextMis_s;
            end else if (drop_r) begin
              // Stale response from before a redirect; refetch at current pc.
              drop_r     <= 1'b0;
              state_r    <= pcMis_s ? TRAP : REQ;
              imemReq_r  <= ~pcMis_s;
              misalign_r <= pcMis_s;
            end else begin
              instr_r      <= imem_rdata;
              instrPc_r    <= pc_r;
              instrValid_r <= 1'b1;
              state_r      <= HOLD;
            end
          end else if (redirect) begin
            pc_r         <= nextPc_s;
            drop_r       <= 1'b1;
            instrValid_r <= 1'b0;
          end
        end
        HOLD: begin
          // A redirect and a consume both move on to next_pc; only the
          // redirect case means the held instruction was not executed.
          if (redirect || instr_ready) begin
            pc_r         <= nextPc_s;
            instrValid_r <= 1'b0;
            state_r      <= nextMis_s ? TRAP : REQ;
            imemReq_r    <= ~nextMis_s;
            misalign_r   <= nextMis_s;
          end
        end
        TRAP: begin
          if (redirect) begin
            pc_r       <= nextPc_s;
            state_r    <= nextMis_s ? TRAP : REQ;
            imemReq_r  <= ~nextMis_s;
            misalign_r <= nextMis_s;
          end
        end
        default: begin
          state_r      <= REQ;
          imemReq_r    <= 1'b0;
          instrValid_r <= 1'b0;
          misalign_r   <= 1'b0;
          drop_r       <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = imemReq_r;
  assign imem_addr      = pc_r;
  assign instr_valid    = instrValid_r;
  assign instr          = instr_r;
  assign instr_pc       = instrPc_r;
  assign fetch_misalign = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level model of the
// fetch stage and a simple instruction memory with variable latency.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  pc_source;
  logic [31:0] branch_target, jump_target, mtvec, mepc;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready;
  logic        fetch_misalign;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_source(pc_source),
    .branch_target(branch_target), .jump_target(jump_target),
    .mtvec(mtvec), .mepc(mepc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_misalign(fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checkEn = 0;

  // Memory knobs and state.
  int gntPct = 100;
  int stallCnt = 0;
  int latency = 0;          // <0 means random 0..3 extra cycles
  int acceptCount = 0;
  logic [31:0] qData[$];
  int          qDly[$];

  // Model state: what the fetch stage is doing, in transaction terms.
  logic [31:0] mPc, mInstr, mInstrPc;
  bit mOut, mDiscard, mValid, mTrap, mQuiet;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  function automatic bit modelReq();
    return !mQuiet && !mTrap && !mOut && !mValid;
  endfunction

  function automatic logic [31:0] modelNext();
    case (pc_source)
      3'd1:    return branch_target;
      3'd2:    return {jump_target[31:1], 1'b0};
      3'd3:    return {mtvec[31:2], 2'b00};
      3'd4:    return mepc;
      default: return mPc + 32'd4;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic waitFor(input bit wantValid, input int maxC, input string nm);
    int n = 0;
    while (((wantValid ? instr_valid : imem_req) !== 1'b1) && n < maxC) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= maxC) begin
      bad++;
      $display("FAIL %s: still low after %0d cycles, required high", nm, n);
    end
  endtask

  // Model update and memory bookkeeping at each rising edge.
  initial forever begin
    logic [31:0] np;
    bit acc;
    int lat;
    @(posedge clk);
    np = modelNext();
    if (!rst_n) begin
      checkEn = 1;
      mPc = 32'h0; mInstr = 32'h0000_0013; mInstrPc = 32'h0;
      mOut = 0; mDiscard = 0; mValid = 0; mTrap = 0; mQuiet = 1;
    end else if (redirect) begin
      acc = modelReq() && (imem_gnt === 1'b1);
      if (mOut) begin
        if (imem_rvalid === 1'b1) begin mOut = 0; mDiscard = 0; end
        else mDiscard = 1;
      end else if (acc) begin
        mOut = 1; mDiscard = 1;
      end
      mValid = 0; mPc = np; mQuiet = 0;
      mTrap = !mOut && (np[1:0] != 2'b00);
    end else if (mTrap) begin
      mTrap = 1;
    end else if (mOut) begin
      if (imem_rvalid === 1'b1) begin
        mOut = 0;
        if (mDiscard) begin
          mDiscard = 0;
          mTrap = (mPc[1:0] != 2'b00);
        end else begin
          mValid = 1; mInstr = imem_rdata; mInstrPc = mPc;
        end
      end
    end else if (mValid) begin
      if (instr_ready === 1'b1) begin
        mValid = 0; mPc = np; mTrap = (np[1:0] != 2'b00);
      end
    end else if (mQuiet) begin
      mQuiet = 0;
    end else if (imem_gnt === 1'b1) begin
      mOut = 1;
    end
    // memory: retire delivered response, age the head, accept a new request
    if (imem_rvalid === 1'b1 && qData.size() > 0) begin
      void'(qData.pop_front());
      void'(qDly.pop_front());
    end
    if (qDly.size() > 0 && qDly[0] > 0) qDly[0] = qDly[0] - 1;
    if (rst_n === 1'b1 && imem_req === 1'b1 && imem_gnt === 1'b1) begin
      lat = (latency < 0) ? int'($urandom_range(0, 3)) : latency;
      qData.push_back(memWord(imem_addr));
      qDly.push_back(lat);
      acceptCount++;
    end
  end

  // Memory drive at the falling edge.
  initial forever begin
    @(negedge clk);
    if (stallCnt > 0) begin
      imem_gnt = 1'b0;
      if (imem_req === 1'b1) stallCnt--;
    end else begin
      imem_gnt = (imem_req === 1'b1) && ($urandom_range(0, 99) < gntPct);
    end
    if (qDly.size() > 0 && qDly[0] == 0) begin
      imem_rvalid = 1'b1; imem_rdata = qData[0];
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, modelReq()});
      check("imem_addr", imem_addr, mPc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, mValid});
      check("instr", instr, mInstr);
      check("instr_pc", instr_pc, mInstrPc);
      check("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, mTrap});
    end
  end

  function automatic logic [31:0] pickTarget(input bit allowOdd);
    logic [31:0] t;
    t = $urandom;
    if (!allowOdd || $urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    int acc0;
    rst_n = 1'b0; redirect = 1'b0; pc_source = 3'd0; instr_ready = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    rst_n = 1'b1;

    // first fetch with single-cycle memory
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_instr", instr, 32'h0000_0093);
    check("first_instr_pc", instr_pc, 32'h0);
    stallCnt = 2; instr_ready = 1'b1; pc_source = 3'd0;
    @(negedge clk);
    instr_ready = 1'b0;
    check("seq_addr", imem_addr, 32'h4);
    acc0 = acceptCount;

    // stalled grant, decode holding off
    waitFor(1'b1, 20, "valid_at_4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_instr", instr, 32'h0004_0093);
      check("hold_pc", instr_pc, 32'h4);
      check("hold_noreq", {31'd0, imem_req}, 32'd0);
    end
    check("single_fetch", acceptCount - acc0, 32'd1);

    // jump clears bit 0
    instr_ready = 1'b1; pc_source = 3'd2; jump_target = 32'h0000_0101;
    @(negedge clk);
    instr_ready = 1'b0;
    check("jump_addr", imem_addr, 32'h0000_0100);
    waitFor(1'b1, 20, "valid_at_100");

    // misaligned branch parks the stage
    instr_ready = 1'b1; pc_source = 3'd1; branch_target = 32'h0000_0042;
    @(negedge clk);
    instr_ready = 1'b0;
    check("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    check("mis_noreq", {31'd0, imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check("mis_held", {31'd0, fetch_misalign}, 32'd1);
    redirect = 1'b1; pc_source = 3'd3; mtvec = 32'h0000_0203; latency = 2;
    @(negedge clk);
    redirect = 1'b0;
    check("mtvec_addr", imem_addr, 32'h0000_0200);
    check("mtvec_req", {31'd0, imem_req}, 32'd1);
    check("mtvec_misalign", {31'd0, fetch_misalign}, 32'd0);

    // redirect while waiting on a slow response
    @(negedge clk);
    redirect = 1'b1; pc_source = 3'd4; mepc = 32'h0000_0080;
    @(negedge clk);
    redirect = 1'b0; latency = 0;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
      check("drop_novalid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("mepc_addr", imem_addr, 32'h0000_0080);
    waitFor(1'b1, 20, "valid_at_80");
    check("mepc_instr_pc", instr_pc, 32'h0000_0080);
    check("mepc_instr", instr, 32'h0080_0093);

    // wrap at the top of the address space
    redirect = 1'b1; pc_source = 3'd1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_valid_clear", {31'd0, instr_valid}, 32'd0);
    waitFor(1'b1, 20, "valid_at_top");
    check("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1; pc_source = 3'd0; latency = 3;
    @(negedge clk);
    instr_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);

    // reset while a response is outstanding; it arrives after release
    @(negedge clk);
    stallCnt = 10; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_valid", {31'd0, instr_valid}, 32'd0);
    check("rstw_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
      check("late_rvalid_addr", imem_addr, 32'h0);
    end
    stallCnt = 0; latency = -1; gntPct = 70;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) == 0 && qData.size() == 0) ? 1'b0 : 1'b1;
      redirect = ($urandom_range(0, 15) == 0) ||
                 (fetch_misalign === 1'b1 && $urandom_range(0, 3) == 0);
      pc_source = 3'($urandom_range(0, 7));
      branch_target = pickTarget(!redirect);
      jump_target   = pickTarget(!redirect);
      mtvec         = $urandom;
      mepc          = pickTarget(!redirect);
      instr_ready   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
